// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel output stage.
// Palette entries are RGB332 approximations of the 16 CGA colors.
package vga_pkg;

    typedef logic [7:0] rgb332_t;

    localparam int FG_MSB    = 3;
    localparam int FG_LSB    = 0;
    localparam int BG_MSB    = 6;
    localparam int BG_LSB    = 4;
    localparam int BLINK_BIT = 7;

    // Packed so that the entry for index 15 comes first and index 0 comes last.
    localparam logic [15:0][7:0] PALETTE = {
        8'hFF, 8'hFD, 8'hEB, 8'hE9, 8'h5F, 8'h5D, 8'h4B, 8'h49,
        8'hB6, 8'h88, 8'h82, 8'h80, 8'h12, 8'h10, 8'h02, 8'h00
    };

endpackage

// File: rtl/vga_blink_timer.sv
// Counts vsync rising edges and toggles blink_phase
// once every BLINK_FRAMES frames.
module vga_blink_timer #(
    parameter int BLINK_FRAMES = 16
) (
    input  logic clock,
    input  logic _reset,
    input  logic vsync,
    output logic blink_phase
);

    logic       vsync_q;
    logic [7:0] frame_cnt;
    logic       vsync_rise;

    assign vsync_rise = vsync & ~vsync_q;

    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            vsync_q     <= 1'b0;
            frame_cnt   <= 8'h00;
            blink_phase <= 1'b0;
        end else begin
            vsync_q <= vsync;
            if (vsync_rise) begin
                if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= 8'h00;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 8'h01;
                end
            end
        end
    end

endmodule

// File: rtl/vga_pixel_out.sv
// Glyph serializer and color resolver. It drives charpixel and the RGB332 DAC value
// once per pixel step.
module vga_pixel_out
    import vga_pkg::*;
#(
    parameter int BLINK_FRAMES = 16
) (
    input  logic       clock,
    input  logic       _reset,
    input  logic       px_clk,
    input  logic       _pe_chpx,
    input  logic [7:0] chr_data,
    input  logic [7:0] col_data,
    input  logic       _charmode,
    input  logic       blank,
    input  logic       vsync,
    output logic       charpixel,
    output rgb332_t    rgb
);

    logic       px_q;
    logic       px_step;
    logic [7:0] shreg;
    logic [7:0] attr;
    logic       blink_phase;
    logic [3:0] color_idx;
    rgb332_t    rgb_next;

    vga_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clock       (clock),
        ._reset      (_reset),
        .vsync       (vsync),
        .blink_phase (blink_phase)
    );

    assign px_step   = px_clk & ~px_q;
    assign charpixel = shreg[7];

    // Color uses the bit currently on charpixel, so rgb trails it by one pixel.
    always_comb begin
        color_idx = {1'b0, attr[BG_MSB:BG_LSB]};
        if (charpixel && !(attr[BLINK_BIT] && blink_phase))
            color_idx = attr[FG_MSB:FG_LSB];
        rgb_next = PALETTE[color_idx];
        if (_charmode)
            rgb_next = col_data;
        if (blank)
            rgb_next = 8'h00;
    end

    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            px_q  <= 1'b0;
            shreg <= 8'h00;
            attr  <= 8'h00;
            rgb   <= 8'h00;
        end else begin
            px_q <= px_clk;
            if (px_step) begin
                if (!_pe_chpx) begin
                    shreg <= chr_data;
                    attr  <= col_data;
                end else begin
                    shreg <= {shreg[6:0], 1'b0};
                end
                rgb <= rgb_next;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_out.sv
// Directed bench for vga_pixel_out. Inputs are driven and outputs sampled on clock negedges.
module tb_vga_pixel_out;

    logic       clock = 1'b0;
    logic       _reset = 1'b0;
    logic       px_clk = 1'b0;
    logic       _pe_chpx = 1'b1;
    logic [7:0] chr_data = 8'h00;
    logic [7:0] col_data = 8'h00;
    logic       _charmode = 1'b0;
    logic       blank = 1'b0;
    logic       vsync = 1'b0;
    logic       charpixel;
    logic [7:0] rgb;

    int n_chk  = 0;
    int n_pass = 0;

    vga_pixel_out #(.BLINK_FRAMES(2)) dut (
        .clock     (clock),
        ._reset    (_reset),
        .px_clk    (px_clk),
        ._pe_chpx  (_pe_chpx),
        .chr_data  (chr_data),
        .col_data  (col_data),
        ._charmode (_charmode),
        .blank     (blank),
        .vsync     (vsync),
        .charpixel (charpixel),
        .rgb       (rgb)
    );

    always #10 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, act, exp);
    endtask

    // One pixel: the pixel step happens on the posedge between the two negedges.
    task automatic pixel();
        @(negedge clock) px_clk = 1'b1;
        @(negedge clock) px_clk = 1'b0;
    endtask

    task automatic frame();
        @(negedge clock) vsync = 1'b1;
        repeat (2) @(negedge clock);
        vsync = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock) _reset = 1'b0;
        repeat (2) @(negedge clock);
        _reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        logic [7:0] glyph;
        logic [7:0] exp_rgb;

        // reset state
        repeat (2) @(negedge clock);
        chk("reset_rgb", rgb, 8'h00);
        chk("reset_charpixel", {7'b0, charpixel}, 8'h00);
        _reset = 1'b1;

        // text glyph 0xA5, fg 15, bg 1
        glyph = 8'hA5;
        _pe_chpx = 1'b0; chr_data = glyph; col_data = 8'h1F;
        pixel();
        _pe_chpx = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("glyph_cp%0d", i), {7'b0, charpixel}, {7'b0, glyph[7-i]});
            pixel();
            exp_rgb = glyph[7-i] ? 8'hFF : 8'h02;
            chk($sformatf("glyph_rgb%0d", i), rgb, exp_rgb);
        end
        chk("glyph_drained", {7'b0, charpixel}, 8'h00);
        pixel();
        chk("glyph_bg", rgb, 8'h02);

        // back-to-back loads
        _pe_chpx = 1'b0; chr_data = 8'hFF;
        pixel();
        chk("load1_cp", {7'b0, charpixel}, 8'h01);
        chr_data = 8'h00;
        pixel();
        chk("load2_cp", {7'b0, charpixel}, 8'h00);
        _pe_chpx = 1'b1;

        // blink with attr 0x8F: phase toggles every 2 frames
        do_reset();
        _pe_chpx = 1'b0; chr_data = 8'hFF; col_data = 8'h8F;
        for (int f = 0; f < 6; f++) begin
            pixel(); pixel();
            exp_rgb = ((f / 2) % 2 == 1) ? 8'h00 : 8'hFF;
            chk($sformatf("blink_f%0d", f), rgb, exp_rgb);
            frame();
        end
        // no blink enable: stays foreground
        do_reset();
        col_data = 8'h0F;
        for (int f = 0; f < 5; f++) begin
            pixel(); pixel();
            chk($sformatf("noblink_f%0d", f), rgb, 8'hFF);
            frame();
        end
        _pe_chpx = 1'b1;

        // graphics mode
        _charmode = 1'b1;
        for (int v = 0; v < 8; v++) begin
            col_data = 8'(v);
            pixel();
            chk($sformatf("gfx_%0d", v), rgb, 8'(v));
        end
        blank = 1'b1; col_data = 8'h55;
        pixel();
        chk("gfx_blank", rgb, 8'h00);
        blank = 1'b0;

        // mode switch mid-line
        _charmode = 1'b0; _pe_chpx = 1'b0; chr_data = 8'hFF; col_data = 8'h1F;
        pixel();
        _pe_chpx = 1'b1; _charmode = 1'b1; col_data = 8'h33;
        pixel();
        chk("switch_gfx", rgb, 8'h33);
        _charmode = 1'b0;
        pixel();
        chk("switch_txt", rgb, 8'hFF);
        _charmode = 1'b1; col_data = 8'h44;
        pixel();
        chk("switch_gfx2", rgb, 8'h44);

        // asynchronous reset mid-stream
        @(negedge clock);
        #2 _reset = 1'b0;
        #1;
        chk("async_rst_rgb", rgb, 8'h00);
        chk("async_rst_cp", {7'b0, charpixel}, 8'h00);
        @(negedge clock) _reset = 1'b1;
        _charmode = 1'b0; _pe_chpx = 1'b0; chr_data = 8'hA5; col_data = 8'h1F;
        pixel();
        chk("post_rst_cp", {7'b0, charpixel}, 8'h01);
        _pe_chpx = 1'b1;
        pixel();
        chk("post_rst_rgb", rgb, 8'hFF);
        chk("post_rst_cp2", {7'b0, charpixel}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
